cam_frame_packer: RTL
=====================

# cam_frame_packer

Capture stage between the OV-series camera pins and `sram_control`. It brings the camera strobes and data into the `clk_100` domain and packs 8-bit pixels into 32-bit words. It writes one frame per vsync into SRAM through a request/acknowledge port, buffering words in a small address+data FIFO. It signals `frame_done` so `jpeg2000_top` can start on a complete frame.

## Interface
- `FRAME_WORDS`, default 16384: 32-bit words per frame (256x256 8-bit pixels).
- `BASE_ADDR`, default 18'h00000: SRAM word address of the first word of each frame.
- `FIFO_DEPTH`, default 4: FIFO entries, power of 2, minimum 2.
- `clk_100`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `configure_over`  in  1  camera register setup complete; enables capture.
- `cam_pclk`  in  1  camera pixel clock; asynchronous, must be ≤ clk_100/4.
- `cam_href`  in  1  line valid; asynchronous.
- `cam_vsyn`  in  1  frame sync, active-high pulse; asynchronous.
- `cam_data`  in  8  pixel byte, valid at `cam_pclk` rise.
- `wr_req`  out  1  FIFO head valid.
- `wr_addr`  out  18  SRAM word address of the FIFO head.
- `wr_data`  out  32  data of the FIFO head.
- `wr_ack`  in  1  head consumed this cycle; only meaningful while `wr_req`=1.
- `frame_done`  out  1  one-cycle pulse when a full frame is in SRAM.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `frame_count`  out  8  completed frames; wraps 255→0.

## Operation
- **Synchronizer.** `cam_pclk`, `cam_href`, `cam_vsyn` and `cam_data` each pass through two flops (s1, s2). A third flop on `pclk` and `vsyn` provides edge detection.
  - Pixel strobe: `pclk_s2 & ~pclk_s3`; it samples `data_s2` and `href_s2`.
  - vsync rising edge: `vsyn_s2 & ~vsyn_s3`.
- **FSM states:** IDLE, ARM, FRAME, FLUSH.
  - IDLE → ARM when `configure_over`=1.
  - ARM → FRAME on vsync rising edge. Entering FRAME clears the byte counter (2b), the word counter, and the partial word, and sets the address to `BASE_ADDR`.
  - In FRAME, a pixel strobe with `href_s2`=1 and `vsyn_s2`=0 shifts the byte in.
    - Byte order is big-endian: 1st byte → [31:24], 4th byte → [7:0].
    - On the 4th byte, push {addr, word}, increment the address (18-bit wrap) and increment the word counter.
  - FRAME → FLUSH when the word counter reaches `FRAME_WORDS`. Pixels arriving in FLUSH and ARM are ignored.
  - A vsync rising edge in FRAME before `FRAME_WORDS` restarts the frame: counters and address are reloaded and the partial word is discarded. Queued entries still drain to their original addresses. `frame_done` does not pulse.
  - FLUSH → ARM on the first cycle with the FIFO empty. That transition pulses `frame_done` and increments `frame_count`.
  - `configure_over`=0 in any state → IDLE next cycle. The partial word is discarded; the FIFO keeps draining.
- **FIFO.** Entries are 50 bits ({addr, data}), `FIFO_DEPTH` deep.
  - `wr_req` = not empty; `wr_addr`/`wr_data` = head.
  - Pop on `wr_req & wr_ack`.
  - A push when full with no pop in the same cycle drops the word and sets `overflow`. The address still increments so later pixels land in their correct positions.
  - A push when full with a pop in the same cycle is accepted.
  - `wr_ack` while empty is ignored.
- `overflow` clears only on `rst`.

## Timing
- After `rst`:
  - outputs: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `overflow`=0, `frame_count`=0.
  - internal: FSM=IDLE, FIFO empty, synchronizer flops 0.
- Pin `cam_pclk` rise → strobe asserts 2–3 `clk_100` cycles later (synchronizer uncertainty).
- 4th-byte strobe in cycle N → push in N+1 → `wr_req`=1 in N+2 if the FIFO was empty.
- Pop in cycle N → next head, or `wr_req`=0, in N+1.
- Last pop in FLUSH in cycle N → FIFO empty in N+1 → `frame_done`=1 in N+2, for exactly one cycle. `frame_count` updates in the same cycle as `frame_done`.
- Vsync rising edge and a pixel strobe in the same cycle: the vsync action wins and the byte is discarded.
- Sustained throughput with `wr_ack` held high: one word per 4 pixel strobes, with no overflow.

## Test plan
- **Basic frame.** `FRAME_WORDS`=4, `BASE_ADDR`=0x100, `wr_ack`=1, `configure_over`=1. Send a vsync pulse, then 16 bytes 0x00..0x0F with `href`=1.
  - Required: writes (0x100, 0x00010203), (0x101, 0x04050607), (0x102, 0x08090A0B), (0x103, 0x0C0D0E0F).
  - Then one `frame_done` pulse and `frame_count`=1.
- **Back-pressure.** Same as basic frame with `wr_ack`=0 for the first 200 cycles.
  - Required: `wr_req` holds the head (0x100, 0x00010203) stable until ack.
  - With `FIFO_DEPTH`=4, all 4 words are retained; `overflow`=0.
  - `frame_done` pulses only after the 4th ack.
- **Overflow.** `FRAME_WORDS`=8, `wr_ack`=0 throughout the frame, then release.
  - Required: the FIFO holds words 0–3; words 4–7 are dropped; `overflow`=1 and stays 1.
  - After release, writes go to addresses 0x100–0x103 only, followed by `frame_done`.
- **Short frame.** A vsync rising edge after 6 bytes.
  - Required: the first word is written at 0x100; bytes 5–6 are discarded.
  - The next frame's first word is also at 0x100; no `frame_done` pulse for the aborted frame.
- **href gating and excess pixels.**
  - Strobes with `href`=0 produce no bytes.
  - Bytes after `FRAME_WORDS` words, before the next vsync, produce no writes.
- **Disable and reset mid-frame.**
  - `configure_over`→0 after 2 bytes: FSM goes to IDLE with no write.
  - `rst`=1 while the FIFO holds 2 entries: `wr_req`=0 the next cycle, all outputs at reset values, `frame_count`=0.

Source files
------------

// File: rtl/cam_frame_packer_if.sv
// SRAM write port of the camera packer: FIFO head offered with a
// request/acknowledge handshake.
interface cam_frame_packer_if;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/cam_frame_packer.sv
// Camera capture: synchronizes OV pins into clk_100, packs bytes big-endian into
// 32-bit words and queues {addr, word} for SRAM, one frame per vsync.
module cam_frame_packer #(
  parameter int          FRAME_WORDS = 16384,
  parameter logic [17:0] BASE_ADDR   = 18'h00000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                 clk_100,
  input  logic                 rst,
  input  logic                 configure_over,
  input  logic                 cam_pclk,
  input  logic                 cam_href,
  input  logic                 cam_vsyn,
  input  logic [7:0]           cam_data,
  cam_frame_packer_if.master   wr,
  output logic                 frame_done,
  output logic                 overflow,
  output logic [7:0]           frame_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, ARM, FRAME, FLUSH} state_e;

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       href_s1_q, href_s2_q;
  logic       vsyn_s1_q, vsyn_s2_q, vsyn_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= '0;
      {href_s1_q, href_s2_q}            <= '0;
      {vsyn_s1_q, vsyn_s2_q, vsyn_s3_q} <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      pclk_s1_q <= cam_pclk;  pclk_s2_q <= pclk_s1_q;  pclk_s3_q <= pclk_s2_q;
      href_s1_q <= cam_href;  href_s2_q <= href_s1_q;
      vsyn_s1_q <= cam_vsyn;  vsyn_s2_q <= vsyn_s1_q;  vsyn_s3_q <= vsyn_s2_q;
      data_s1_q <= cam_data;  data_s2_q <= data_s1_q;
    end
  end

  logic strobe, vsyn_rise;
  assign strobe    = pclk_s2_q & ~pclk_s3_q;
  assign vsyn_rise = vsyn_s2_q & ~vsyn_s3_q;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [31:0]      word_q;
  logic [17:0]      addr_q;
  logic             push_vld_q;
  logic [49:0]      push_entry_q;
  logic             frame_done_q;
  logic [7:0]       frame_count_q;
  logic             frame_load, accept, done_d;
  logic             fifo_empty, fifo_full, pop, push_ok, drop;

  always_ff @(posedge clk_100) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // vsync beats a same-cycle pixel strobe: the restart branch is taken first
  always_comb begin
    state_d    = state_q;
    frame_load = 1'b0;
    accept     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE:  if (configure_over) state_d = ARM;
      ARM:   if (vsyn_rise) begin
               state_d    = FRAME;
               frame_load = 1'b1;
             end
      FRAME: if (vsyn_rise)                              frame_load = 1'b1;
             else if (word_cnt_q == WCW'(FRAME_WORDS))   state_d    = FLUSH;
             else if (strobe && href_s2_q && !vsyn_s2_q) accept     = 1'b1;
      FLUSH: if (fifo_empty) begin
               state_d = ARM;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
    if (!configure_over) begin
      state_d    = IDLE;
      frame_load = 1'b0;
      accept     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      word_q        <= '0;
      addr_q        <= BASE_ADDR;
      push_vld_q    <= 1'b0;
      push_entry_q  <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      push_vld_q   <= 1'b0;
      frame_done_q <= done_d;
      if (done_d) frame_count_q <= frame_count_q + 8'd1;
      if (frame_load) begin
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
        word_q     <= '0;
        addr_q     <= BASE_ADDR;
      end else if (accept) begin
        word_q     <= {word_q[23:0], data_s2_q};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          push_vld_q   <= 1'b1;
          push_entry_q <= {addr_q, word_q[23:0], data_s2_q};
          addr_q       <= addr_q + 18'd1;
          word_cnt_q   <= word_cnt_q + 1'b1;
        end
      end else if (!configure_over) begin
        byte_cnt_q <= '0;
        word_q     <= '0;
      end
    end
  end

  logic [49:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic [49:0]   head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && wr.wr_ack;
  assign push_ok    = push_vld_q && (!fifo_full || pop);
  assign drop       = push_vld_q && fifo_full && !pop;

  always_ff @(posedge clk_100) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_q;
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Head is masked while empty so the port idles at zero
  assign head        = mem_q[rd_ptr_q];
  assign wr.wr_req   = !fifo_empty;
  assign wr.wr_addr  = fifo_empty ? '0 : head[49:32];
  assign wr.wr_data  = fifo_empty ? '0 : head[31:0];
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
endmodule
